// File: rtl/filter_bank.sv
// ============================================================================
// Module   : filter_bank
// Purpose  : Per-channel glitch filters with true/complement outputs, change
//            pulses, and an optional grouped snapshot scan port.
//            Optional feature macro: FILTER_BANK_SCAN_EN (scan port built).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_bank #(
    parameter  int CHANNELS = 32,
    parameter  int DEPTH    = 4,
    parameter  int LANES    = 8,
    localparam int GROUPS   = CHANNELS / LANES,
    localparam int GW       = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [0:CHANNELS-1] raw_in,
    input  logic                bypass,
    output logic [0:CHANNELS-1] filt_out,
    output logic [0:CHANNELS-1] filt_n_out,
    output logic [0:CHANNELS-1] change_pulse,
    input  logic                scan_start,
    output logic                scan_busy,
    output logic                scan_valid,
    input  logic                scan_ready,
    output logic [GW-1:0]       scan_group,
    output logic [0:LANES-1]    scan_data,
    output logic                scan_done
);

    localparam logic [7:0] C_DEPTH_M1 = 8'(DEPTH - 1);

    logic [0:CHANNELS-1] w_filt;
    logic [0:CHANNELS-1] w_chg;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic       r_filt;
        logic       r_chg;
        logic [7:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_filt <= 1'b0;
                r_chg  <= 1'b0;
                r_cnt  <= 8'd0;
            end else if (bypass) begin
                r_filt <= raw_in[n];
                r_chg  <= raw_in[n] ^ r_filt;
                r_cnt  <= 8'd0;
            end else if (raw_in[n] == r_filt) begin
                r_chg  <= 1'b0;
                r_cnt  <= 8'd0;
            end else if (r_cnt == C_DEPTH_M1) begin
                r_filt <= raw_in[n];
                r_chg  <= 1'b1;
                r_cnt  <= 8'd0;
            end else begin
                r_chg  <= 1'b0;
                r_cnt  <= r_cnt + 8'd1;
            end
        end

        assign w_filt[n] = r_filt;
        assign w_chg[n]  = r_chg;
    end

    assign filt_out     = w_filt;
    assign filt_n_out   = ~w_filt;
    assign change_pulse = w_chg;

`ifdef FILTER_BANK_SCAN_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SHOW = 2'd2
    } scan_state_t;

    localparam logic [GW-1:0] C_LAST_GROUP = GW'(GROUPS - 1);

    scan_state_t         r_state;
    logic [0:CHANNELS-1] r_snap;
    logic [GW-1:0]       r_group;
    logic                w_show;

    // Snapshot takes the pre-edge filter state so a scan never mixes old/new levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_snap  <= '0;
            r_group <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (scan_start) begin
                        r_snap  <= w_filt;
                        r_group <= '0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: r_state <= S_SHOW;
                S_SHOW: begin
                    if (scan_ready) begin
                        if (r_group == C_LAST_GROUP) begin
                            r_group <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_group <= r_group + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_show     = (r_state == S_SHOW);
    assign scan_valid = w_show;
    assign scan_busy  = (r_state != S_IDLE);
    assign scan_done  = w_show & scan_ready & (r_group == C_LAST_GROUP);
    assign scan_group = w_show ? r_group : '0;
    assign scan_data  = w_show ? r_snap[int'(r_group) * LANES +: LANES] : '0;
`else
    logic w_unused_scan;

    assign w_unused_scan = scan_start ^ scan_ready;
    assign scan_busy     = 1'b0;
    assign scan_valid    = 1'b0;
    assign scan_done     = 1'b0;
    assign scan_group    = '0;
    assign scan_data     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_filter_bank.sv
// ============================================================================
// Module   : tb_filter_bank
// Purpose  : Directed self-checking bench for filter_bank (32 ch, depth 4, 8 lanes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_filter_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:31] raw_in;
    logic        bypass;
    logic [0:31] filt_out;
    logic [0:31] filt_n_out;
    logic [0:31] change_pulse;
    logic        scan_start;
    logic        scan_busy;
    logic        scan_valid;
    logic        scan_ready;
    logic [1:0]  scan_group;
    logic [0:7]  scan_data;
    logic        scan_done;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;

    filter_bank #(.CHANNELS(32), .DEPTH(4), .LANES(8)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw_in       (raw_in),
        .bypass       (bypass),
        .filt_out     (filt_out),
        .filt_n_out   (filt_n_out),
        .change_pulse (change_pulse),
        .scan_start   (scan_start),
        .scan_busy    (scan_busy),
        .scan_valid   (scan_valid),
        .scan_ready   (scan_ready),
        .scan_group   (scan_group),
        .scan_data    (scan_data),
        .scan_done    (scan_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (scan_done === 1'b1) n_done++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] acc;
        int          pulses;
        logic        v;

        rst_n      = 1'b1;
        raw_in     = '0;
        bypass     = 1'b0;
        scan_start = 1'b0;
        scan_ready = 1'b0;

        // Asynchronous reset assertion before any clock edge
        #3 rst_n = 1'b0;
        #1;
        check_val("rst_filt",   filt_out,     32'h0000_0000);
        check_val("rst_filt_n", filt_n_out,   32'hFFFF_FFFF);
        check_val("rst_chg",    change_pulse, 32'h0000_0000);
        check_val("rst_valid",  {31'd0, scan_valid}, 32'd0);
        check_val("rst_busy",   {31'd0, scan_busy},  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Odd-channel pattern
        raw_in = 32'h5555_5555;
        repeat (3) tick();
        check_val("pat_pre", filt_out, 32'h0000_0000);
        tick();
        check_val("pat_filt",   filt_out,     32'h5555_5555);
        check_val("pat_filt_n", filt_n_out,   32'hAAAA_AAAA);
        check_val("pat_chg",    change_pulse, 32'h5555_5555);
        tick();
        check_val("pat_chg_off", change_pulse, 32'h0000_0000);

        // Three-cycle glitch is swallowed
        acc = '0;
        raw_in[3] = 1'b0;
        repeat (3) begin
            tick();
            acc = acc | change_pulse;
        end
        raw_in[3] = 1'b1;
        repeat (3) begin
            tick();
            acc = acc | change_pulse;
        end
        check_val("glitch_filt", filt_out, 32'h5555_5555);
        check_val("glitch_chg",  acc,      32'h0000_0000);

        // Four-cycle low is accepted with a single pulse
        pulses = 0;
        raw_in[3] = 1'b0;
        repeat (3) begin
            tick();
            if (change_pulse != 0) pulses++;
        end
        check_val("ch3_hold", filt_out, 32'h5555_5555);
        tick();
        if (change_pulse != 0) pulses++;
        check_val("ch3_filt", filt_out,     32'h4555_5555);
        check_val("ch3_chg",  change_pulse, 32'h1000_0000);
        repeat (3) begin
            tick();
            if (change_pulse != 0) pulses++;
        end
        check_val("ch3_pulses", pulses, 32'd1);
        raw_in[3] = 1'b1;
        repeat (5) tick();
        check_val("ch3_back", filt_out, 32'h5555_5555);

`ifdef FILTER_BANK_SCAN_EN
        // Scan with ready toggling
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        check_val("s1_load_busy",  {31'd0, scan_busy},  32'd1);
        check_val("s1_load_valid", {31'd0, scan_valid}, 32'd0);
        tick();
        for (int g = 0; g < 4; g++) begin
            scan_ready = 1'b0;
            #1;
            check_val("s1_valid", {31'd0, scan_valid}, 32'd1);
            check_val("s1_group", {30'd0, scan_group}, g);
            check_val("s1_data",  {24'd0, scan_data},  32'h55);
            check_val("s1_done_stall", {31'd0, scan_done}, 32'd0);
            tick();
            check_val("s1_hold_group", {30'd0, scan_group}, g);
            check_val("s1_hold_data",  {24'd0, scan_data},  32'h55);
            scan_ready = 1'b1;
            #1;
            check_val("s1_done", {31'd0, scan_done}, (g == 3) ? 32'd1 : 32'd0);
            tick();
        end
        scan_ready = 1'b0;
        check_val("s1_end_busy",  {31'd0, scan_busy},  32'd0);
        check_val("s1_end_valid", {31'd0, scan_valid}, 32'd0);
        check_val("s1_end_data",  {24'd0, scan_data},  32'd0);
        check_val("s1_dones",     n_done, 32'd1);

        // Snapshot stays frozen while inputs drop mid-scan
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        raw_in = '0;
        tick();
        repeat (4) tick();
        check_val("s2_filt_now", filt_out, 32'h0000_0000);
        check_val("s2_stall_group", {30'd0, scan_group}, 32'd0);
        scan_ready = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            check_val("s2_group", {30'd0, scan_group}, g);
            check_val("s2_data",  {24'd0, scan_data},  32'h55);
            check_val("s2_done",  {31'd0, scan_done}, (g == 3) ? 32'd1 : 32'd0);
            tick();
        end
        check_val("s2_end_busy", {31'd0, scan_busy}, 32'd0);

        // Second scan with ready already high sees the new all-zero state
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        tick();
        for (int g = 0; g < 4; g++) begin
            check_val("s3_valid", {31'd0, scan_valid}, 32'd1);
            check_val("s3_group", {30'd0, scan_group}, g);
            check_val("s3_data",  {24'd0, scan_data},  32'h00);
            tick();
        end
        scan_ready = 1'b0;
        check_val("s3_dones", n_done, 32'd3);
`else
        raw_in = '0;
        repeat (5) tick();
        check_val("noscan_filt", filt_out, 32'h0000_0000);
        scan_ready = 1'b1;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        acc = '0;
        repeat (4) begin
            tick();
            acc = acc | {scan_busy, scan_valid, scan_done, scan_group, 19'd0, scan_data};
        end
        check_val("noscan_outs", acc, 32'd0);
        scan_ready = 1'b0;
`endif

        // Bypass: follows raw with one-cycle latency, pulsing on each change
        bypass = 1'b1;
        for (int i = 0; i < 6; i++) begin
            v = (i % 2 == 0);
            raw_in[0] = v;
            tick();
            check_val("byp_filt", filt_out,     v ? 32'h8000_0000 : 32'h0);
            check_val("byp_chg",  change_pulse, 32'h8000_0000);
        end
        bypass = 1'b0;
        tick();
        check_val("byp_off_chg", change_pulse, 32'h0);

`ifdef FILTER_BANK_SCAN_EN
        // Reset during beat 2 aborts the scan without a done pulse
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        tick();
        scan_ready = 1'b1;
        tick();
        tick();
        scan_ready = 1'b0;
        #1;
        check_val("mr_group", {30'd0, scan_group}, 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check_val("mr_valid", {31'd0, scan_valid}, 32'd0);
        check_val("mr_busy",  {31'd0, scan_busy},  32'd0);
        check_val("mr_done",  {31'd0, scan_done},  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_val("mr_idle_busy", {31'd0, scan_busy}, 32'd0);
        check_val("mr_dones", n_done, 32'd3);
`else
        #3 rst_n = 1'b0;
        #1;
        check_val("mr_filt_n", filt_n_out, 32'hFFFF_FFFF);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_val("mr_dones", n_done, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/filter_bank.md
# filter_bank

Parametrised bank of per-channel digital glitch filters: each of CHANNELS single-bit inputs must hold a new level for DEPTH consecutive clocks before the filtered output follows it. Sits between raw asynchronous-ish status lines (already synchronised upstream) and control logic. Provides true and complement filtered vectors and one-cycle change pulses. Also provides a snapshot scan port that reads the filtered state out in groups of LANES channels over a valid/ready handshake.

## Interface
- CHANNELS, 32: number of filter channels; must be a multiple of LANES.
- DEPTH, 4: consecutive differing samples required to accept a new level; valid range is 1 to 255.
- LANES, 8: channels per scan beat; GROUPS = CHANNELS/LANES; GW = max(1, $clog2(GROUPS)).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- raw_in  in  [0:CHANNELS-1]  unfiltered inputs; bit n is channel n.
- bypass  in  1  when high, filters are bypassed and the output registers follow raw_in with 1-cycle latency.
- filt_out  out  [0:CHANNELS-1]  filtered level per channel.
- filt_n_out  out  [0:CHANNELS-1]  bitwise complement of filt_out.
- change_pulse  out  [0:CHANNELS-1]  high for one cycle when the corresponding filt_out bit changes.
- scan_start  in  1  request a scan; sampled only in IDLE.
- scan_busy  out  1  high in LOAD and SHOW.
- scan_valid  out  1  scan beat available.
- scan_ready  in  1  consumer accepts the beat.
- scan_group  out  [GW-1:0]  index of the current beat.
- scan_data  out  [0:LANES-1]  lane k carries snapshot channel scan_group*LANES+k.
- scan_done  out  1  one-cycle pulse on acceptance of the last beat.

## Operation
- Per channel, state is filt (1 bit) and cnt (8 bits). At each edge:
  - raw == filt: cnt <= 0.
  - raw != filt and cnt == DEPTH-1: filt <= raw, cnt <= 0, change <= 1.
  - Otherwise: cnt <= cnt+1.
  - change is 0 on every edge where filt does not update.
- Any return of raw to filt resets cnt, so a glitch shorter than DEPTH cycles never propagates.
- DEPTH=1: filt follows raw with 1-cycle latency.
- bypass=1: filt <= raw, cnt <= 0, change <= (raw != filt).
- Deasserting bypass resumes filtering from the current filt with cnt=0.
- filt_n_out is derived combinationally as ~filt_out.
- Scan FSM states:
  - IDLE: scan_start=1 → capture snapshot <= filt (the value before this edge's update), group <= 0, next state LOAD.
  - LOAD: one cycle, then SHOW.
  - SHOW: scan_valid=1. On valid&&ready: if group == GROUPS-1 → scan_done=1 and go to IDLE; else group <= group+1 and stay in SHOW.
- The snapshot is frozen for the whole scan; filt changes mid-scan never tear the beats.
- scan_start while busy is ignored; there is no queuing.
- scan_ready may be high before scan_valid. scan_data and scan_group are stable while valid && !ready.
- scan_data and scan_group read 0 outside SHOW.

## Timing
- Reset (async assert, sync-to-clock release) clears:
  - filt_out=0 and filt_n_out=all ones.
  - change_pulse=0 and every cnt=0.
  - The FSM to IDLE, with scan_valid=scan_busy=scan_done=0 and scan_group=0.
- Reset mid-scan drops scan_valid and scan_busy immediately; no scan_done is produced.
- Filter latency: a new level first sampled at edge t appears on filt_out after edge t+DEPTH-1. change_pulse is high during the same cycle the new filt_out value is first visible.
- Scan latency: scan_start at edge t → LOAD after t, scan_valid after t+1. One beat per cycle with ready held high.
- A full scan takes GROUPS+2 cycles from start to return to IDLE. scan_done is high during the last-beat handshake cycle.

## Configuration
- FILTER_BANK_SCAN_EN:
  - Defined: the snapshot register, scan FSM and scan outputs are built as specified.
  - Undefined: no snapshot or FSM logic is built; scan_start and scan_ready are ignored; scan_busy, scan_valid, scan_done, scan_group and scan_data are tied to 0.
  - Filtering is identical either way.

## Test plan
All scenarios use CHANNELS=32, DEPTH=4, LANES=8.
- Reset: assert rst_n=0 mid-clock → filt_out=0, filt_n_out=32'hFFFF_FFFF, change_pulse=0, scan_valid=0 without waiting for clk.
- Odd-channel pattern: from reset apply raw_in[n]=n&1 and hold → after the 4th edge filt_out has odd channels=1 (32'h5555_5555). change_pulse is high on odd channels for exactly one cycle; filt_n_out=32'hAAAA_AAAA.
- Glitch: raw_in[3] driven to 0 for 3 cycles then back to 1 → filt_out[3] stays 1, no change_pulse. Driving it to 0 for 4 cycles → filt_out[3]=0 and a single pulse.
- Scan with stalls: after the pattern is settled, pulse scan_start with scan_ready toggling 1,0,1,0… → 4 beats, groups 0..3, each scan_data=8'b0101_0101 (lanes 1,3,5,7 set). Data holds while ready=0; scan_done pulses once; scan_busy is low afterwards.
- Snapshot integrity: start a scan, then set raw_in=all zeros held 4 cycles during SHOW → all beats still show the pattern. A second scan afterwards returns all-zero beats.
- Bypass and mid-scan reset: with bypass=1, toggle raw_in[0] every cycle → filt_out[0] follows with 1-cycle delay and pulses every cycle. Asserting rst_n=0 during beat 2 → scan_valid and scan_busy go to 0 and scan_done never asserts.
